// File: rtl/light_timing_planner_if.sv
// ============================================================================
//  Module      : light_timing_planner_if
//  Description : Signal bundle between the light timing planner and the
//                traffic light controller it feeds.
//                  lightType    - controller phase (0 red, 1 yellow,
//                                 2 green, 3 invalid)
//                  carSense     - one-cycle pulse per car at the stop line
//                  walkRaw      - raw, asynchronous pedestrian button
//                  gLength      - green length for the next green phase
//                  yLength      - yellow length (constant)
//                  rLength      - red length for the next red phase
//                  walkButton   - latched, debounced walk request
//                  queueCount   - cars queued during last non-green interval
//                  updateStrobe - one-cycle pulse when lengths are committed
//                Modport master is the planner side; slave is the
//                controller/sensor side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface light_timing_planner_if #(
  parameter int LEN_W = 11
) ();
  logic [1:0]       lightType;
  logic             carSense;
  logic             walkRaw;
  logic [LEN_W-1:0] gLength;
  logic [LEN_W-1:0] yLength;
  logic [LEN_W-1:0] rLength;
  logic             walkButton;
  logic [8:0]       queueCount;
  logic             updateStrobe;

  modport master (
    input  lightType,
    input  carSense,
    input  walkRaw,
    output gLength,
    output yLength,
    output rLength,
    output walkButton,
    output queueCount,
    output updateStrobe
  );

  modport slave (
    output lightType,
    output carSense,
    output walkRaw,
    input  gLength,
    input  yLength,
    input  rLength,
    input  walkButton,
    input  queueCount,
    input  updateStrobe
  );
endinterface

`default_nettype wire

// File: rtl/light_timing_planner.sv
// ============================================================================
//  Module      : light_timing_planner
//  Description : Upstream stage of the traffic light controller. Watches the
//                controller phase for boundaries, counts cars queued during
//                red/yellow, adapts the next green length within bounds, and
//                debounces the pedestrian button into a latched request that
//                holds until the walk phase has been served.
//  Ports       : clock  - system clock, rising edge
//                reset  - asynchronous active-high reset, clears all state
//                bus    - light_timing_planner_if.master (phase in, car and
//                         button inputs, phase lengths / walk / status out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_timing_planner #(
  parameter int LEN_W     = 11,
  parameter int G_DEFAULT = 8,
  parameter int G_MIN     = 4,
  parameter int G_MAX     = 32,
  parameter int G_STEP    = 2,
  parameter int Y_LEN     = 2,
  parameter int R_DEFAULT = 8,
  parameter int R_WALK    = 12,
  parameter int HI_THRESH = 6,
  parameter int LO_THRESH = 2,
  parameter int DEBOUNCE  = 3
) (
  input  wire logic              clock,
  input  wire logic              reset,
  light_timing_planner_if.master bus
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] c_red    = 2'd0;
  localparam logic [1:0] c_yellow = 2'd1;
  localparam logic [1:0] c_green  = 2'd2;
  localparam logic [1:0] c_inval  = 2'd3;

  localparam logic [8:0]       c_cnt_max = 9'h1FF;
  localparam logic [8:0]       c_hi      = 9'(HI_THRESH);
  localparam logic [8:0]       c_lo      = 9'(LO_THRESH);
  // Green arithmetic is one bit wider than the outputs so it cannot wrap.
  localparam logic [LEN_W:0]   c_g_max   = (LEN_W+1)'(G_MAX);
  localparam logic [LEN_W:0]   c_g_min   = (LEN_W+1)'(G_MIN);
  localparam logic [LEN_W:0]   c_g_step  = (LEN_W+1)'(G_STEP);
  localparam logic [LEN_W-1:0] c_g_def   = LEN_W'(G_DEFAULT);
  localparam logic [LEN_W-1:0] c_y_len   = LEN_W'(Y_LEN);
  localparam logic [LEN_W-1:0] c_r_def   = LEN_W'(R_DEFAULT);
  localparam logic [LEN_W-1:0] c_r_walk  = LEN_W'(R_WALK);
  localparam logic [DEB_W-1:0] c_deb_max = DEB_W'(DEBOUNCE);
  localparam logic [DEB_W-1:0] c_deb_pre = DEB_W'(DEBOUNCE - 1);

  logic [1:0]       prev_type_q, prev_type_d;
  logic [8:0]       car_cnt_q,   car_cnt_d;
  logic [8:0]       queue_q,     queue_d;
  logic [LEN_W-1:0] pend_g_q,    pend_g_d;
  logic [LEN_W-1:0] g_len_q,     g_len_d;
  logic [LEN_W-1:0] r_len_q,     r_len_d;
  logic             strobe_q,    strobe_d;
  logic             sync1_q,     sync1_d;
  logic             sync2_q,     sync2_d;
  logic [DEB_W-1:0] deb_q,       deb_d;
  logic             walk_q,      walk_d;
  logic             served_q,    served_d;

  logic             w_invalid;
  logic             w_green_start;
  logic             w_yellow_start;
  logic             w_red_start;
  logic             w_deb_done;
  logic [LEN_W:0]   w_g_ext;
  logic [LEN_W:0]   w_g_up;
  logic [LEN_W:0]   w_g_dn;

  always_comb begin
    w_invalid      = (bus.lightType == c_inval);
    w_green_start  = (prev_type_q == c_red)    && (bus.lightType == c_green);
    w_yellow_start = (prev_type_q == c_green)  && (bus.lightType == c_yellow);
    w_red_start    = (prev_type_q == c_yellow) && (bus.lightType == c_red);

    // The invalid code is ignored entirely: the last valid phase is kept so
    // a glitch through 3 does not fabricate or hide a boundary.
    prev_type_d = w_invalid ? prev_type_q : bus.lightType;

    // Car counter: only cars waiting at red/yellow are queued.
    car_cnt_d = car_cnt_q;
    if (w_green_start) begin
      car_cnt_d = 9'd0;
    end else if (((bus.lightType == c_red) || (bus.lightType == c_yellow)) &&
                 bus.carSense && (car_cnt_q != c_cnt_max)) begin
      car_cnt_d = car_cnt_q + 9'd1;
    end

    // Next-green computation from the queue snapshot at green entry.
    w_g_ext  = {1'b0, g_len_q};
    w_g_up   = w_g_ext + c_g_step;
    w_g_dn   = w_g_ext - c_g_step;
    queue_d  = queue_q;
    pend_g_d = pend_g_q;
    if (w_green_start) begin
      queue_d = car_cnt_q;
      if (car_cnt_q >= c_hi) begin
        pend_g_d = (w_g_up > c_g_max) ? c_g_max[LEN_W-1:0] : w_g_up[LEN_W-1:0];
      end else if (car_cnt_q <= c_lo) begin
        // Compare before subtracting so a small gLength never underflows.
        pend_g_d = (w_g_ext <= (c_g_min + c_g_step)) ? c_g_min[LEN_W-1:0]
                                                     : w_g_dn[LEN_W-1:0];
      end else begin
        pend_g_d = g_len_q;
      end
    end

    // Commit one phase later, at yellow entry, so lengths never change while
    // the controller is timing the phase that uses them.
    g_len_d  = g_len_q;
    r_len_d  = r_len_q;
    strobe_d = w_yellow_start;
    if (w_yellow_start) begin
      g_len_d = pend_g_q;
      r_len_d = walk_q ? c_r_walk : c_r_def;
    end

    // Walk request path.
    sync1_d    = bus.walkRaw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    walk_d     = walk_q;
    served_d   = served_q;
    w_deb_done = 1'b0;
    if (!w_invalid) begin
      if (sync2_q) begin
        // Saturating counter: a held button latches only once.
        deb_d = (deb_q == c_deb_max) ? deb_q : deb_q + DEB_W'(1);
      end else begin
        deb_d = '0;
      end
      w_deb_done = sync2_q && (deb_q == c_deb_pre);

      // A request is cleared only after it has seen a whole red phase, so a
      // press that lands during red is carried to the following red.
      if (w_red_start) begin
        served_d = walk_q;
      end
      if (w_green_start) begin
        if (served_q) begin
          walk_d = 1'b0;
        end
        served_d = 1'b0;
      end
      // A fresh press beats a simultaneous clear.
      if (w_deb_done) begin
        walk_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_type_q <= c_red;
      car_cnt_q   <= 9'd0;
      queue_q     <= 9'd0;
      pend_g_q    <= c_g_def;
      g_len_q     <= c_g_def;
      r_len_q     <= c_r_def;
      strobe_q    <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= '0;
      walk_q      <= 1'b0;
      served_q    <= 1'b0;
    end else begin
      prev_type_q <= prev_type_d;
      car_cnt_q   <= car_cnt_d;
      queue_q     <= queue_d;
      pend_g_q    <= pend_g_d;
      g_len_q     <= g_len_d;
      r_len_q     <= r_len_d;
      strobe_q    <= strobe_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      walk_q      <= walk_d;
      served_q    <= served_d;
    end
  end

  assign bus.gLength      = g_len_q;
  assign bus.yLength      = c_y_len;
  assign bus.rLength      = r_len_q;
  assign bus.walkButton   = walk_q;
  assign bus.queueCount   = queue_q;
  assign bus.updateStrobe = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_light_timing_planner.sv
// ============================================================================
//  Module      : tb_light_timing_planner
//  Description : Self-checking bench for light_timing_planner. A table of
//                full red->green->yellow cycles with hand-computed results,
//                plus hand-written sequences for the invalid phase code,
//                queue saturation and asynchronous reset mid-yellow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_light_timing_planner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  light_timing_planner_if #(.LEN_W(11)) bus ();

  light_timing_planner dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_before;
    int cars;
    int walk_red;
    int walk_green;
    int exp_q;
    int exp_walk_entry;
    int exp_walk_end;
    int exp_g;
    int exp_r;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rb, int cars, int wr, int wg, int q,
                              int we, int wend, int g, int r);
    vec_t v;
    v.rst_before = rb; v.cars = cars; v.walk_red = wr; v.walk_green = wg;
    v.exp_q = q; v.exp_walk_entry = we; v.exp_walk_end = wend;
    v.exp_g = g; v.exp_r = r;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] lt, input logic cs, input logic wr);
    bus.lightType = lt;
    bus.carSense  = cs;
    bus.walkRaw   = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.lightType = 2'd0;
    bus.carSense  = 1'b0;
    bus.walkRaw   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One red -> green -> yellow cycle; returns observed values at key points.
  task automatic do_cycle(input int cars, input int walk_red, input int walk_green,
                          output int q, output int we, output int wend,
                          output int g, output int r, output int s1, output int s2);
    step(2'd0, 1'b0, 1'b0);
    for (int i = 0; i < cars; i++) begin
      step(2'd0, 1'b1, 1'b0);
      step(2'd0, 1'b0, 1'b0);
    end
    for (int i = 0; i < walk_red; i++) step(2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(2'd0, 1'b0, 1'b0);
    step(2'd2, 1'b1, 1'b0);   // carSense on green entry must not be counted
    q  = int'(bus.queueCount);
    we = int'(bus.walkButton);
    for (int i = 0; i < walk_green; i++) step(2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(2'd2, 1'b0, 1'b0);
    wend = int'(bus.walkButton);
    step(2'd1, 1'b0, 1'b0);
    g  = int'(bus.gLength);
    r  = int'(bus.rLength);
    s1 = int'(bus.updateStrobe);
    step(2'd1, 1'b0, 1'b0);
    s2 = int'(bus.updateStrobe);
  endtask

  initial begin
    int q, we, wend, g, r, s1, s2;

    // Growth to the ceiling: 7 cars per red.
    for (int k = 0; k < 13; k++) begin
      int eg;
      eg = 8 + 2 * (k + 1);
      if (eg > 32) eg = 32;
      tbl.push_back(mk(1'b0, 7, 0, 0, 7, 0, 0, eg, 8));
    end
    // Threshold boundaries and the floor.
    tbl.push_back(mk(1'b1, 2, 0, 0, 2, 0, 0, 6, 8));
    tbl.push_back(mk(1'b0, 6, 0, 0, 6, 0, 0, 8, 8));
    tbl.push_back(mk(1'b0, 5, 0, 0, 5, 0, 0, 8, 8));
    tbl.push_back(mk(1'b0, 3, 0, 0, 3, 0, 0, 8, 8));
    tbl.push_back(mk(1'b0, 1, 0, 0, 1, 0, 0, 6, 8));
    tbl.push_back(mk(1'b0, 1, 0, 0, 1, 0, 0, 4, 8));
    tbl.push_back(mk(1'b0, 0, 0, 0, 0, 0, 0, 4, 8));
    tbl.push_back(mk(1'b0, 4, 0, 0, 4, 0, 0, 4, 8));
    // Walk request handling.
    tbl.push_back(mk(1'b0, 4, 0, 2, 4, 0, 0, 4, 8));   // short press rejected
    tbl.push_back(mk(1'b0, 4, 0, 5, 4, 0, 1, 4, 12));  // press during green
    tbl.push_back(mk(1'b0, 4, 0, 0, 4, 0, 0, 4, 8));   // served, cleared
    tbl.push_back(mk(1'b0, 4, 5, 0, 4, 1, 1, 4, 12));  // press during red survives
    tbl.push_back(mk(1'b0, 4, 0, 0, 4, 0, 0, 4, 8));   // cleared after next red

    bus.lightType = 2'd0;
    bus.carSense  = 1'b0;
    bus.walkRaw   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_gLength",      int'(bus.gLength),      8);
    chk("rst_yLength",      int'(bus.yLength),      2);
    chk("rst_rLength",      int'(bus.rLength),      8);
    chk("rst_walkButton",   int'(bus.walkButton),   0);
    chk("rst_queueCount",   int'(bus.queueCount),   0);
    chk("rst_updateStrobe", int'(bus.updateStrobe), 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      do_cycle(tbl[i].cars, tbl[i].walk_red, tbl[i].walk_green,
               q, we, wend, g, r, s1, s2);
      chk($sformatf("row%0d_queueCount", i),  q,    tbl[i].exp_q);
      chk($sformatf("row%0d_walk_entry", i),  we,   tbl[i].exp_walk_entry);
      chk($sformatf("row%0d_walk_end", i),    wend, tbl[i].exp_walk_end);
      chk($sformatf("row%0d_gLength", i),     g,    tbl[i].exp_g);
      chk($sformatf("row%0d_rLength", i),     r,    tbl[i].exp_r);
      chk($sformatf("row%0d_strobe_on", i),   s1,   1);
      chk($sformatf("row%0d_strobe_off", i),  s2,   0);
    end

    // Invalid phase code: cars ignored, held red history still yields green entry.
    step(2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 1'b1, 1'b0);
      step(2'd0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(2'd3, 1'b1, 1'b0);
    chk("inv_no_strobe", int'(bus.updateStrobe), 0);
    step(2'd2, 1'b0, 1'b0);
    chk("inv_queueCount", int'(bus.queueCount), 3);
    step(2'd2, 1'b0, 1'b0);
    step(2'd1, 1'b0, 1'b0);
    chk("inv_gLength", int'(bus.gLength), 4);
    chk("inv_strobe",  int'(bus.updateStrobe), 1);

    // Queue saturation, then asynchronous reset mid-yellow.
    do_reset();
    step(2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      step(2'd0, 1'b1, 1'b0);
      step(2'd0, 1'b0, 1'b0);
    end
    step(2'd2, 1'b0, 1'b0);
    chk("sat_queueCount", int'(bus.queueCount), 511);
    for (int i = 0; i < 5; i++) step(2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(2'd2, 1'b0, 1'b0);
    step(2'd1, 1'b0, 1'b0);
    chk("sat_gLength",    int'(bus.gLength),    10);
    chk("sat_rLength",    int'(bus.rLength),    12);
    chk("sat_walkButton", int'(bus.walkButton), 1);
    rst = 1'b1;
    #2;
    chk("async_gLength",      int'(bus.gLength),      8);
    chk("async_yLength",      int'(bus.yLength),      2);
    chk("async_rLength",      int'(bus.rLength),      8);
    chk("async_walkButton",   int'(bus.walkButton),   0);
    chk("async_queueCount",   int'(bus.queueCount),   0);
    chk("async_updateStrobe", int'(bus.updateStrobe), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
